// File: rtl/rx_link_ctrl_pkg.sv
// Shared types and constants for the receive link controller.
// Comma patterns, state encoding and counter sizing helper.
package rx_link_ctrl_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] COMMA_P = 10'b0011111010;
    localparam logic [SYM_W-1:0] COMMA_N = 10'b1100000101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ALIGN  = 2'd2,
        ST_LOCKED = 2'd3
    } link_state_e;

    // Counter width for a terminal count n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_comma_detect.sv
// Serial-to-parallel shift register and K28.5 comma matcher.
// Idle cycles shift in zeros and can never report a match.
module rx_comma_detect
    import rx_link_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             rx_bit,
    input  logic             elec_idle,
    output logic [SYM_W-1:0] sr_next,
    output logic             match
);

    logic [SYM_W-1:0] sr;
    logic             b;

    // Oldest bit ends up in bit 0; match looks at the post-shift window.
    always_comb begin
        b       = elec_idle ? 1'b0 : rx_bit;
        sr_next = {b, sr[SYM_W-1:1]};
        match   = !elec_idle &&
                  ((sr_next == COMMA_P) || (sr_next == COMMA_N));
    end

    // Shift register advances on every enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (enb) begin
            sr <= sr_next;
        end
    end

endmodule

// File: rtl/rx_link_ctrl.sv
// Receive link controller: wake, comma alignment and lock supervision.
// Emits one aligned symbol every ten cycles while locked.
module rx_link_ctrl
    import rx_link_ctrl_pkg::*;
#(
    parameter int WAKE_CNT      = 8,
    parameter int IDLE_CNT      = 4,
    parameter int ALIGN_TIMEOUT = 256,
    parameter int SKP_INTERVAL  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             rx_bit,
    input  logic             elec_idle,
    output logic [SYM_W-1:0] symbol,
    output logic             symbol_valid,
    output logic             is_comma,
    output logic             locked,
    output logic [1:0]       state,
    output logic             align_err,
    output logic             lock_lost
);

    localparam int WAKE_W = cnt_w(WAKE_CNT);
    localparam int IDLE_W = cnt_w(IDLE_CNT);
    localparam int TMO_W  = cnt_w(ALIGN_TIMEOUT);
    localparam int SKP_W  = cnt_w(SKP_INTERVAL);
    localparam int BIT_W  = cnt_w(SYM_W);

    logic [SYM_W-1:0]  sr_next;
    logic              match;

    link_state_e       state_q, state_n;
    logic [WAKE_W-1:0] wake_q, wake_n;
    logic [IDLE_W-1:0] idle_q, idle_n;
    logic [TMO_W-1:0]  tmo_q, tmo_n;
    logic [SKP_W-1:0]  scnt_q, scnt_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic [SYM_W-1:0]  sym_q, sym_n;
    logic              sv_q, sv_n;
    logic              comma_q, comma_n;
    logic              aerr_q, aerr_n;
    logic              lost_q, lost_n;
    logic              locked_q, locked_n;
    logic              idle_exit;
    logic              starve;

    rx_comma_detect u_comma (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .rx_bit    (rx_bit),
        .elec_idle (elec_idle),
        .sr_next   (sr_next),
        .match     (match)
    );

    // State register plus every counter and registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wake_q   <= '0;
            idle_q   <= '0;
            tmo_q    <= '0;
            scnt_q   <= '0;
            bit_q    <= '0;
            sym_q    <= '0;
            sv_q     <= 1'b0;
            comma_q  <= 1'b0;
            aerr_q   <= 1'b0;
            lost_q   <= 1'b0;
            locked_q <= 1'b0;
        end else if (enb) begin
            state_q  <= state_n;
            wake_q   <= wake_n;
            idle_q   <= idle_n;
            tmo_q    <= tmo_n;
            scnt_q   <= scnt_n;
            bit_q    <= bit_n;
            sym_q    <= sym_n;
            sv_q     <= sv_n;
            comma_q  <= comma_n;
            aerr_q   <= aerr_n;
            lost_q   <= lost_n;
            locked_q <= locked_n;
        end else begin
            // A strobe must not reappear when the lane is re-enabled.
            sv_q   <= 1'b0;
            aerr_q <= 1'b0;
            lost_q <= 1'b0;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_n   = state_q;
        wake_n    = wake_q;
        idle_n    = idle_q;
        tmo_n     = tmo_q;
        scnt_n    = scnt_q;
        bit_n     = bit_q;
        sym_n     = sym_q;
        sv_n      = 1'b0;
        comma_n   = 1'b0;
        aerr_n    = 1'b0;
        lost_n    = 1'b0;
        starve    = 1'b0;
        idle_exit = elec_idle && (idle_q == IDLE_W'(IDLE_CNT - 1));

        unique case (state_q)
            ST_IDLE: begin
                wake_n = '0;
                idle_n = '0;
                if (!elec_idle) begin
                    state_n = ST_WAKE;
                    wake_n  = WAKE_W'(1);
                end
            end
            ST_WAKE: begin
                if (elec_idle) begin
                    state_n = ST_IDLE;
                    wake_n  = '0;
                end else if (wake_q == WAKE_W'(WAKE_CNT - 1)) begin
                    state_n = ST_ALIGN;
                    wake_n  = '0;
                    tmo_n   = '0;
                    idle_n  = '0;
                end else begin
                    wake_n = wake_q + 1'b1;
                end
            end
            ST_ALIGN: begin
                tmo_n  = tmo_q + 1'b1;
                idle_n = elec_idle ? idle_q + 1'b1 : '0;
                if (idle_exit) begin
                    state_n = ST_IDLE;
                    idle_n  = '0;
                    tmo_n   = '0;
                end else if (match) begin
                    state_n = ST_LOCKED;
                    sym_n   = sr_next;
                    sv_n    = 1'b1;
                    comma_n = 1'b1;
                    bit_n   = '0;
                    scnt_n  = '0;
                    tmo_n   = '0;
                end else if (tmo_q == TMO_W'(ALIGN_TIMEOUT - 1)) begin
                    aerr_n = 1'b1;
                    tmo_n  = '0;
                end
            end
            ST_LOCKED: begin
                idle_n = elec_idle ? idle_q + 1'b1 : '0;
                if (bit_q == BIT_W'(SYM_W - 1)) begin
                    bit_n   = '0;
                    sym_n   = sr_next;
                    sv_n    = 1'b1;
                    comma_n = match;
                    if (match) begin
                        scnt_n = '0;
                    end else if (scnt_q == SKP_W'(SKP_INTERVAL - 1)) begin
                        starve = 1'b1;
                        scnt_n = '0;
                    end else begin
                        scnt_n = scnt_q + 1'b1;
                    end
                end else begin
                    bit_n = bit_q + 1'b1;
                end
                // Idle exit outranks comma starvation; one lock_lost either way.
                if (idle_exit) begin
                    state_n = ST_IDLE;
                    lost_n  = 1'b1;
                    idle_n  = '0;
                end else if (starve) begin
                    state_n = ST_ALIGN;
                    lost_n  = 1'b1;
                    tmo_n   = '0;
                    idle_n  = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        locked_n = (state_n == ST_LOCKED);
    end

    assign symbol       = sym_q;
    assign symbol_valid = sv_q & enb;
    assign is_comma     = comma_q;
    assign locked       = locked_q;
    assign state        = state_q;
    assign align_err    = aerr_q & enb;
    assign lock_lost    = lost_q & enb;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Directed bench for rx_link_ctrl.
// Hand-computed expectations for wake, lock, idle, starvation and freeze.
module tb_rx_link_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b1;
    logic       rx_bit = 1'b0;
    logic       elec_idle = 1'b1;
    logic [9:0] symbol;
    logic       symbol_valid;
    logic       is_comma;
    logic       locked;
    logic [1:0] state;
    logic       align_err;
    logic       lock_lost;

    int n_chk  = 0;
    int n_pass = 0;

    int         cyc     = 0;
    int         sv_hits = 0;
    int         sv_cyc  = 0;
    logic [9:0] sv_sym  = '0;
    logic       sv_com  = 1'b0;
    int         ll_hits = 0;
    int         ae_hits = 0;
    int         ae_cyc  = 0;

    localparam logic [9:0] C_P   = 10'b0011111010;
    localparam logic [9:0] C_N   = 10'b1100000101;
    localparam logic [9:0] D21_5 = 10'b1010101010;

    rx_link_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .rx_bit       (rx_bit),
        .elec_idle    (elec_idle),
        .symbol       (symbol),
        .symbol_valid (symbol_valid),
        .is_comma     (is_comma),
        .locked       (locked),
        .state        (state),
        .align_err    (align_err),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic b, input logic idle);
        rx_bit    = b;
        elec_idle = idle;
        @(posedge clk);
        #1;
        cyc++;
        if (symbol_valid) begin
            sv_hits++;
            sv_cyc = cyc;
            sv_sym = symbol;
            sv_com = is_comma;
        end
        if (lock_lost) ll_hits++;
        if (align_err) begin
            ae_hits++;
            ae_cyc = cyc;
        end
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) tick(s[i], 1'b0);
    endtask

    int h0, l0, c0, a0;
    logic bad;

    initial begin
        // Reset with random serial data.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({symbol, symbol_valid, is_comma,
                              locked, align_err, lock_lost}), 32'd0);
        rst = 1'b0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("idle_hold", 32'(state), 32'd0);

        // Wake glitch after five good cycles.
        tick(1'b0, 1'b0);
        check("wake_enter", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        check("wake_5", 32'(state), 32'd1);
        tick(1'b0, 1'b1);
        check("wake_glitch", 32'(state), 32'd0);
        tick(1'b0, 1'b0);
        check("wake_again", 32'(state), 32'd1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        check("wake_7", 32'(state), 32'd1);
        tick(1'b0, 1'b0);
        check("align_enter", 32'(state), 32'd2);

        // Lock on COMMA_P.
        h0 = sv_hits;
        send_sym(C_P);
        check("lock_hits", 32'(sv_hits - h0), 32'd1);
        check("lock_valid", 32'(symbol_valid), 32'd1);
        check("lock_sym", 32'(symbol), 32'h0FA);
        check("lock_comma", 32'(is_comma), 32'd1);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_state", 32'(state), 32'd3);

        // Data symbols land exactly every ten cycles.
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            h0 = sv_hits;
            c0 = cyc;
            send_sym(D21_5);
            if (sv_hits - h0 != 1 || sv_cyc != c0 + 10 ||
                sv_sym != D21_5 || sv_com) bad = 1'b1;
        end
        check("data_cadence", 32'(bad), 32'd0);

        // Freeze mid-symbol for seven cycles.
        for (int i = 0; i < 4; i++) tick(D21_5[i], 1'b0);
        h0 = sv_hits;
        enb = 1'b0;
        for (int i = 0; i < 7; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        check("frz_valid", 32'(sv_hits - h0), 32'd0);
        check("frz_state", 32'(state), 32'd3);
        enb = 1'b1;
        c0 = cyc;
        for (int i = 4; i < 10; i++) tick(D21_5[i], 1'b0);
        check("frz_resume", 32'(sv_hits - h0), 32'd1);
        check("frz_phase", 32'(sv_cyc - c0), 32'd6);
        check("frz_sym", 32'(sv_sym), 32'h2AA);

        // Short idle run keeps lock.
        l0 = ll_hits;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 3; i < 10; i++) tick(D21_5[i], 1'b0);
        check("idle3_lost", 32'(ll_hits - l0), 32'd0);
        check("idle3_locked", 32'(locked), 32'd1);
        check("idle3_sym", 32'(sv_sym), 32'h2A8);

        // Four idle cycles drop to IDLE.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        check("idle4_lost", 32'(lock_lost), 32'd1);
        check("idle4_state", 32'(state), 32'd0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("idle4_once", 32'(ll_hits - l0), 32'd1);
        check("idle4_locked", 32'(locked), 32'd0);

        // Re-lock, then starve of commas.
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        send_sym(C_P);
        check("relock", 32'(state), 32'd3);
        l0 = ll_hits;
        for (int k = 0; k < 63; k++) send_sym(D21_5);
        check("skp63_state", 32'(state), 32'd3);
        check("skp63_lost", 32'(ll_hits - l0), 32'd0);
        send_sym(D21_5);
        check("skp64_lost", 32'(ll_hits - l0), 32'd1);
        check("skp64_state", 32'(state), 32'd2);
        check("skp64_locked", 32'(locked), 32'd0);

        // ALIGN timeout after 256 comma-free cycles.
        a0 = ae_hits;
        c0 = cyc;
        for (int i = 0; i < 255; i++) tick(D21_5[i % 10], 1'b0);
        check("tmo255", 32'(ae_hits - a0), 32'd0);
        tick(D21_5[5], 1'b0);
        check("tmo256", 32'(ae_hits - a0), 32'd1);
        check("tmo_cyc", 32'(ae_cyc - c0), 32'd256);
        for (int i = 0; i < 10; i++) tick(D21_5[i], 1'b0);
        check("tmo_once", 32'(ae_hits - a0), 32'd1);
        check("tmo_state", 32'(state), 32'd2);

        // Lock on the negative-disparity comma.
        h0 = sv_hits;
        send_sym(C_N);
        check("lockn_hits", 32'(sv_hits - h0), 32'd1);
        check("lockn_sym", 32'(sv_sym), 32'h305);
        check("lockn_comma", 32'(sv_com), 32'd1);
        check("lockn_state", 32'(state), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_link_ctrl.md
Name: rx_link_ctrl

Overview:
- Receive-side link controller placed directly after the differential receiver.
- Takes the recovered serial bit and the electrical-idle flag each clock and sequences the lane: IDLE -> WAKE -> ALIGN -> LOCKED.
- Finds 10-bit symbol boundaries with the K28.5 comma, then emits one aligned 10-bit symbol every 10 clocks to the 8b/10b decoder.
- Monitors idle and comma spacing and drops lock when either fails.

Parameters:
- WAKE_CNT, 8: consecutive non-idle cycles required to leave WAKE.
- IDLE_CNT, 4: consecutive idle cycles in ALIGN/LOCKED that force a return to IDLE.
- ALIGN_TIMEOUT, 256: cycles allowed in ALIGN without a comma before align_err.
- SKP_INTERVAL, 64: maximum symbols in LOCKED without a comma before lock loss.

Ports:
- clk, input, 1: single clock, one serial bit per cycle.
- rst, input, 1: synchronous, active-high reset.
- enb, input, 1: global enable; 0 freezes all state.
- rx_bit, input, 1: serial bit from the differential receiver.
- elec_idle, input, 1: electrical-idle flag from the differential receiver.
- symbol, output, 10: aligned symbol; first-received bit is in symbol[0].
- symbol_valid, output, 1: one-cycle strobe, symbol is valid.
- is_comma, output, 1: qualifies symbol_valid; symbol is COMMA_P or COMMA_N.
- locked, output, 1: high while in LOCKED.
- state, output, 2: current state; IDLE=0, WAKE=1, ALIGN=2, LOCKED=3.
- align_err, output, 1: one-cycle pulse on ALIGN timeout.
- lock_lost, output, 1: one-cycle pulse on exit from LOCKED.

Behaviour:
- Reset: on rst=1 at a clock edge, all outputs, the shift register and all counters go to 0, and state goes to IDLE. rst has priority over enb.
- Enable: enb=0 holds every register. symbol_valid, align_err and lock_lost are forced to 0 while enb=0.
- Shift register: 10-bit sr. Each enabled edge performs sr <= {b, sr[9:1]}, where b = elec_idle ? 0 : rx_bit.
- Comma match: sr_next equals COMMA_P (10'b0011111010) or COMMA_N (10'b1100000101), and elec_idle=0 in that cycle. An idle cycle never produces a match.
- IDLE:
  - wake counter cleared; locked=0.
  - Go to WAKE on the first cycle with elec_idle=0.
- WAKE:
  - Count consecutive cycles with elec_idle=0.
  - Any cycle with elec_idle=1 returns to IDLE and clears the count.
  - When the count reaches WAKE_CNT, go to ALIGN with the timeout counter at 0.
- ALIGN:
  - Timeout counter increments each cycle.
  - On a comma match: next state LOCKED; symbol <= sr_next; symbol_valid=1; is_comma=1; locked=1; bit_cnt=0; sym_cnt=0.
  - On timeout (count reaches ALIGN_TIMEOUT-1 with no match): align_err pulses once, the counter restarts, and the state stays ALIGN.
  - IDLE_CNT consecutive idle cycles go to IDLE. An idle run shorter than IDLE_CNT resets the idle counter and has no other effect.
- LOCKED:
  - bit_cnt counts 0..9 and wraps.
  - Each time bit_cnt wraps to 0, i.e. every 10th cycle after the lock cycle: symbol <= sr_next, symbol_valid=1, is_comma set from the match.
  - sym_cnt clears on a comma symbol and increments on every other symbol.
  - sym_cnt reaching SKP_INTERVAL: lock_lost pulses, state goes to ALIGN, locked=0.
  - IDLE_CNT consecutive idle cycles: lock_lost pulses, state goes to IDLE.
  - A comma found at an off-boundary offset while LOCKED is ignored; no realignment.
- Simultaneous events: if idle exit and sym_cnt overflow occur in the same cycle, IDLE wins and lock_lost pulses once.
- Register timing: all outputs are registered. A comma's last bit sampled at edge k produces symbol_valid high in cycle k+1.
- Shared counter widths: $clog2 of the corresponding parameter, minimum 1.

Decomposition:
- Shared include file rx_link_defs.vh:
  - COMMA_P and COMMA_N constants.
  - State encodings (IDLE=0, WAKE=1, ALIGN=2, LOCKED=3).
  - Symbol width 10.
- One natural sub-module, rx_comma_detect:
  - Owns the shift register and the combinational match.
  - Exposes sr_next and a match flag.
- The FSM and all counters stay in rx_link_ctrl.
- Instrumentation for the transition-count memory follows the existing SIMULATION_conductual convention, with parameter PwrC.

Test Plan:
- Reset: hold rst=1 for 3 cycles with random rx_bit -> state=0 and all outputs 0; deassert with elec_idle=1 -> state stays 0.
- Wake and lock: elec_idle=0 for 8 cycles -> state=2; send COMMA_P LSB-first -> one cycle later symbol=10'h0FA, symbol_valid=1, is_comma=1, locked=1. Continue with D21.5 -> symbol_valid exactly every 10 cycles with is_comma=0.
- Wake glitch: elec_idle=0 for 5 cycles, then 1 for 1 cycle, then 0 -> state returns to 0, then 1; ALIGN is reached only after 8 fresh cycles.
- Idle handling in LOCKED: 3 idle cycles -> still locked, no lock_lost. A later run of 4 idle cycles -> lock_lost pulses once, state=0, locked=0.
- Comma starvation: after lock, 64 consecutive non-comma symbols -> lock_lost pulses, state=2. In ALIGN, 256 cycles with no comma -> align_err pulses exactly once, state stays 2.
- Enable freeze: in LOCKED, deassert enb for 7 cycles -> symbol_valid=0 and state/counters frozen; on re-enable the symbol cadence resumes with the same phase.
